// File: rtl/b_iq_pkg.sv
// Shared defaults and elaboration helpers for the module-B input qualifier.
package b_iq_pkg;

    localparam int NCH_DEF         = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int STABLE_CNT_DEF  = 4;
    localparam int CNT_W_DEF       = 3;
    localparam int FIFO_DEPTH      = 2;

    // True when a cnt_w-bit counter can reach stable_cnt-1 without wrapping.
    function automatic bit iq_cnt_fits(input int cnt_w, input int stable_cnt);
        return (2 ** cnt_w) > stable_cnt;
    endfunction

endpackage

// File: rtl/b_iq_filter_ch.sv
// One channel: synchronizer chain, stability counter and the qualified level bit.
module b_iq_filter_ch
    import b_iq_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int STABLE_CNT  = STABLE_CNT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_q,
    output logic o_q_next
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_q;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];
    assign o_q = r_q;

    // A differing level must be seen STABLE_CNT edges in a row; any match restarts the count.
    always_comb begin
        o_q_next   = r_q;
        w_cnt_next = '0;
        if (w_s != r_q) begin
            if (r_cnt == CNT_W'(STABLE_CNT - 1)) o_q_next   = ~r_q;
            else                                 w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_q    <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_q    <= o_q_next;
            r_cnt  <= w_cnt_next;
        end
    end

endmodule

// File: rtl/b_input_qualifier.sv
// De-glitched pad inputs for module B, with every qualified change posted to a 2-entry event FIFO.
module b_input_qualifier
    import b_iq_pkg::*;
#(
    parameter int NCH         = NCH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int STABLE_CNT  = STABLE_CNT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    inout  wire            VDD,
    inout  wire            VSS,
    input  logic [NCH-1:0] in_raw,
    output logic [NCH-1:0] q_level,
    output logic           evt_valid,
    output logic [NCH-1:0] evt_data,
    input  logic           evt_ready,
    output logic           ovf,
    input  logic           ovf_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH + 1);

    if (!iq_cnt_fits(CNT_W, STABLE_CNT) || SYNC_STAGES < 2 || SYNC_STAGES > 3
        || STABLE_CNT < 1 || STABLE_CNT > 7) begin : g_bad_cfg
        $error("b_input_qualifier: illegal parameter combination");
    end

    logic                                w_unused_pwr;
    logic [NCH-1:0]                      w_q;
    logic [NCH-1:0]                      w_q_next;
    logic                                w_push;
    logic                                w_pop;
    logic                                w_drop;
    logic [FIFO_DEPTH-1:0][NCH-1:0]      r_mem;
    logic [FIFO_DEPTH-1:0][NCH-1:0]      w_mem_next;
    logic [PTR_W-1:0]                    r_cnt;
    logic [PTR_W-1:0]                    w_cnt_next;
    logic                                r_ovf;

    assign w_unused_pwr = VDD ^ VSS;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        b_iq_filter_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .STABLE_CNT (STABLE_CNT),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_raw   (in_raw[g]),
            .o_q     (w_q[g]),
            .o_q_next(w_q_next[g])
        );
    end

    assign w_push = (w_q_next != w_q);
    assign w_pop  = (r_cnt != '0) && evt_ready;

    // Shift-register FIFO: head is always entry 0, vacated slots are zeroed so an empty head reads 0.
    always_comb begin
        w_mem_next = r_mem;
        w_cnt_next = r_cnt;
        w_drop     = 1'b0;
        if (w_pop) begin
            for (int e = 0; e < FIFO_DEPTH - 1; e++) w_mem_next[e] = r_mem[e+1];
            w_mem_next[FIFO_DEPTH-1] = '0;
            w_cnt_next = r_cnt - PTR_W'(1);
        end
        if (w_push) begin
            if (w_cnt_next == PTR_W'(FIFO_DEPTH)) begin
                w_drop = 1'b1;
            end else begin
                for (int e = 0; e < FIFO_DEPTH; e++)
                    if (PTR_W'(e) == w_cnt_next) w_mem_next[e] = w_q_next;
                w_cnt_next = w_cnt_next + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_mem <= w_mem_next;
            r_cnt <= w_cnt_next;
            if (w_drop)       r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;
        end
    end

    assign q_level   = w_q;
    assign evt_valid = (r_cnt != '0);
    assign evt_data  = r_mem[0];
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_b_input_qualifier.sv
// Directed plus random stimulus for b_input_qualifier, checked every cycle against a behavioural model.
module tb_b_input_qualifier;

    localparam int NCH   = 4;
    localparam int SS    = 2;
    localparam int SC    = 4;
    localparam int DEPTH = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    wire            vdd = 1'b1;
    wire            vss = 1'b0;
    logic [NCH-1:0] in_raw = '0;
    logic           evt_ready = 1'b0;
    logic           ovf_clr = 1'b0;
    logic [NCH-1:0] q_level;
    logic           evt_valid;
    logic [NCH-1:0] evt_data;
    logic           ovf;

    int errors = 0;
    int checks = 0;

    // Model: raw sample history, per-channel mismatch streak, event queue, sticky overflow.
    logic [NCH-1:0] m_q;
    int             m_run [NCH];
    logic [NCH-1:0] m_hist[SS];
    logic [NCH-1:0] m_fifo[$];
    logic           m_ovf;

    b_input_qualifier dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .VDD      (vdd),
        .VSS      (vss),
        .in_raw   (in_raw),
        .q_level  (q_level),
        .evt_valid(evt_valid),
        .evt_data (evt_data),
        .evt_ready(evt_ready),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q   = '0;
        m_ovf = 1'b0;
        m_fifo.delete();
        for (int c = 0; c < NCH; c++) m_run[c] = 0;
        for (int k = 0; k < SS; k++) m_hist[k] = '0;
    endtask

    task automatic model_step();
        logic [NCH-1:0] s, qn;
        logic pop, drop;
        // the filter sees the raw value sampled SS edges earlier
        s = m_hist[SS-1];
        for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = in_raw;
        qn = m_q;
        for (int c = 0; c < NCH; c++) begin
            if (s[c] != m_q[c]) begin
                m_run[c]++;
                if (m_run[c] == SC) begin
                    qn[c]    = ~m_q[c];
                    m_run[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
        end
        pop  = (m_fifo.size() != 0) && evt_ready;
        drop = 1'b0;
        if (pop) void'(m_fifo.pop_front());
        if (qn != m_q) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(qn);
            else                       drop = 1'b1;
        end
        if (drop)         m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        m_q = qn;
    endtask

    task automatic check_all();
        chk("q_level", q_level, m_q);
        chk("evt_valid", evt_valid, m_fifo.size() != 0);
        chk("evt_data", evt_data, (m_fifo.size() != 0) ? m_fifo[0] : '0);
        chk("ovf", ovf, m_ovf);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (rst_n) model_step();
            #1;
            check_all();
        end
    endtask

    initial begin
        int hold;
        hold = 0;
        model_reset();

        // reset with all inputs high
        in_raw = 4'hF;
        #1;
        check_all();
        ticks(3);
        rst_n = 1'b1;
        ticks(6);
        chk("rel_q", q_level, 4'hF);
        chk("rel_evt_valid", evt_valid, 1'b1);
        chk("rel_evt_data", evt_data, 4'hF);
        evt_ready = 1'b1;
        ticks(1);
        chk("rel_pop", evt_valid, 1'b0);
        in_raw = 4'h0;
        ticks(8);

        // 3-cycle glitch is rejected, 4-cycle pulse is accepted
        evt_ready = 1'b0;
        in_raw = 4'h2; ticks(3);
        in_raw = 4'h0; ticks(8);
        chk("glitch_q", q_level, 4'h0);
        chk("glitch_evt", evt_valid, 1'b0);
        in_raw = 4'h2; ticks(4);
        in_raw = 4'h0; ticks(2);
        chk("pulse_q", q_level, 4'h2);
        chk("pulse_evt", evt_data, 4'h2);
        ticks(8);
        evt_ready = 1'b1; ticks(3);

        // two channels on one edge give one event
        evt_ready = 1'b0;
        in_raw = 4'h5; ticks(6);
        chk("multi_q", q_level, 4'h5);
        chk("multi_evt", evt_data, 4'h5);
        ticks(2);
        evt_ready = 1'b1; ticks(1);
        chk("multi_single", evt_valid, 1'b0);
        in_raw = 4'h0; ticks(8);

        // overflow with stalled consumer
        evt_ready = 1'b0;
        in_raw = 4'h1; ticks(8);
        in_raw = 4'h3; ticks(8);
        in_raw = 4'h7; ticks(8);
        chk("ovf_set", ovf, 1'b1);
        chk("ovf_q", q_level, 4'h7);
        chk("ovf_head", evt_data, 4'h1);
        evt_ready = 1'b1; ticks(1);
        chk("ovf_pop1", evt_data, 4'h3);
        ticks(1);
        chk("ovf_pop2", evt_valid, 1'b0);
        evt_ready = 1'b0;

        // clear, refill, then push and pop on the same edge while full
        ovf_clr = 1'b1; ticks(1);
        chk("ovf_clr", ovf, 1'b0);
        ovf_clr = 1'b0;
        in_raw = 4'h6; ticks(8);
        in_raw = 4'h4; ticks(8);
        in_raw = 4'h0; ticks(5);
        evt_ready = 1'b1; ticks(1);
        chk("full_pp_q", q_level, 4'h0);
        chk("full_pp_ovf", ovf, 1'b0);
        chk("full_pp_head", evt_data, 4'h4);
        ticks(1);
        chk("full_pp_next", evt_data, 4'h0);
        ticks(1);
        chk("full_pp_empty", evt_valid, 1'b0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            if (hold == 0) begin
                in_raw = 4'($urandom);
                hold   = $urandom_range(1, 7);
            end
            hold--;
            evt_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            ticks(1);
        end

        // async reset with queued events
        ovf_clr = 1'b0;
        evt_ready = 1'b0;
        in_raw = ~m_q;        ticks(8);
        in_raw = m_q ^ 4'h1;  ticks(8);
        chk("pre_rst_valid", evt_valid, 1'b1);
        #3;
        rst_n = 1'b0;
        in_raw = 4'h0;
        #1;
        chk("async_valid", evt_valid, 1'b0);
        chk("async_q", q_level, 4'h0);
        chk("async_data", evt_data, 4'h0);
        model_reset();
        ticks(2);
        rst_n = 1'b1;
        ticks(6);
        chk("no_evt_on_release", evt_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
